data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Single-outstanding request/response memory responder: a 2^ADDR_W x 16-bit
//   word memory with random read/write access and a downward-growing stack
//   (push/pop) sharing the same array. Every request takes LATENCY cycles from
//   accept to a one-cycle response pulse.
//
// Parameters
//   ADDR_W   word-address width (memory holds 2^ADDR_W words)
//   LATENCY  cycles from accept to response, 1..15
//   SP_INIT  stack pointer reset value (empty-stack position)
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active low
//   req_valid/req_ready request handshake; ready only while idle
//   req_read/write/push/pop  operation select, one-hot
//   req_addr            word address for read/write
//   req_wdata           data for write/push
//   resp_valid          one-cycle response pulse
//   resp_data           read/pop data, 0 for write/push/error
//   resp_err            request rejected, qualified by resp_valid
//   sp_out              current stack pointer
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int SP_INIT = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic              req_write,
  input  logic              req_push,
  input  logic              req_pop,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] sp_out
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_INIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        op_q;           // {read, write, push, pop}
  logic [15:0]       addr_q, wdata_q;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic [15:0]       mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  // With LATENCY=1 the commit edge is the accept edge itself, so the request
  // is decoded straight from the inputs while idle and from the captured
  // copy otherwise.
  logic [3:0]        cur_op;
  logic [15:0]       cur_addr, cur_wdata;
  logic              op_rd, op_wr, op_push, op_pop;
  logic              addr_in_range, req_err, commit;
  logic [ADDR_W-1:0] word_addr, sp_above, rd_addr;
  logic [15:0]       rd_data;

  assign cur_op    = (state_q == S_IDLE) ? {req_read, req_write, req_push, req_pop} : op_q;
  assign cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign {op_rd, op_wr, op_push, op_pop} = cur_op;

  assign addr_in_range = (cur_addr >> ADDR_W) == 16'd0;
  assign word_addr     = cur_addr[ADDR_W-1:0];
  assign sp_above      = sp_q + ADDR_W'(1);

  // Guards make SP arithmetic wrap-free: no push when full, no pop when empty.
  assign req_err = !$onehot(cur_op)
                || ((op_rd || op_wr) && !addr_in_range)
                || (op_push && (sp_q == '0))
                || (op_pop  && (sp_q == SP_RST));

  assign rd_addr = op_pop ? sp_above : word_addr;
  assign rd_data = mem[rd_addr];

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sp_d        = sp_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    commit      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        // Leave on the edge where the count reaches 0, so RESP begins exactly
        // LATENCY cycles after the accept cycle.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // rst gates the commit so a clock edge during reset cannot touch the array.
    if (commit && rst) begin
      resp_err_d  = req_err;
      resp_data_d = '0;
      if (!req_err) begin
        if (op_rd) begin
          resp_data_d = rd_data;
        end else if (op_wr) begin
          mem_we    = 1'b1;
          mem_waddr = word_addr;
          mem_wdata = cur_wdata;
        end else if (op_push) begin
          mem_we    = 1'b1;
          mem_waddr = sp_q;
          mem_wdata = cur_wdata;
          sp_d      = sp_q - ADDR_W'(1);
        end else begin
          resp_data_d = rd_data;
          sp_d        = sp_above;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sp_q        <= SP_RST;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sp_q        <= sp_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      if (state_q == S_IDLE && req_valid) begin
        op_q    <= {req_read, req_write, req_push, req_pop};
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // NOTE: the array has no reset; clearing it would prevent RAM inference
  // and nothing depends on its power-up contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign sp_out     = sp_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder: a vector table of single requests on
//   a LATENCY=2 instance, plus hand sequences for reset, reset-abort, stack
//   full, and back-to-back throughput on a LATENCY=1 instance.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam logic [3:0] RD = 4'b1000;
  localparam logic [3:0] WR = 4'b0100;
  localparam logic [3:0] PU = 4'b0010;
  localparam logic [3:0] PO = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // LATENCY=2 instance
  logic        req_valid = 1'b0, req_ready;
  logic        req_read = 1'b0, req_write = 1'b0, req_push = 1'b0, req_pop = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [15:0] resp_data;
  logic [9:0]  sp_out;

  // LATENCY=1 instance
  logic        l1_req_valid = 1'b0, l1_req_ready;
  logic        l1_req_read = 1'b0, l1_req_write = 1'b0, l1_req_push = 1'b0, l1_req_pop = 1'b0;
  logic [15:0] l1_req_addr = '0, l1_req_wdata = '0;
  logic        l1_resp_valid, l1_resp_err;
  logic [15:0] l1_resp_data;
  logic [9:0]  l1_sp_out;

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write), .req_push(req_push), .req_pop(req_pop),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .sp_out(sp_out)
  );

  data_mem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_read(l1_req_read), .req_write(l1_req_write), .req_push(l1_req_push), .req_pop(l1_req_pop),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
    .resp_valid(l1_resp_valid), .resp_data(l1_resp_data), .resp_err(l1_resp_err),
    .sp_out(l1_sp_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic        exp_err;
    logic [9:0]  exp_sp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] wd, input logic [15:0] ed,
                              input logic ee, input logic [9:0] es);
    vec_t v;
    v.name = n; v.op = op; v.addr = a; v.wdata = wd;
    v.exp_data = ed; v.exp_err = ee; v.exp_sp = es;
    return v;
  endfunction

  // Issues one request on the LATENCY=2 instance starting from idle, scrambles
  // the request inputs right after the accept, and watches a fixed window.
  // lat is the number of cycles after the accept cycle at which resp_valid is
  // first seen (-1 if never), pulses counts resp_valid cycles, low counts
  // cycles with req_ready low.
  task automatic run_req(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] wd,
                         output logic [15:0] rdata, output logic rerr,
                         output int lat, output int pulses, output int low);
    @(negedge clk);
    {req_read, req_write, req_push, req_pop} = op;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    {req_read, req_write, req_push, req_pop} = 4'b1111;
    req_addr  = ~addr;
    req_wdata = ~wd;
    rdata = 16'hDEAD; rerr = 1'bx; lat = -1; pulses = 0; low = 0;
    for (int k = 1; k <= 6; k++) begin
      if (!req_ready) low++;
      if (resp_valid) begin
        pulses++;
        if (lat < 0) begin
          lat   = k;
          rdata = resp_data;
          rerr  = resp_err;
        end
      end
      @(negedge clk);
    end
    {req_read, req_write, req_push, req_pop} = 4'b0000;
  endtask

  initial begin
    logic [15:0] rdata;
    logic        rerr;
    int          lat, pulses, low, errs;

    // ---------------- reset state ----------------
    #1 rst = 1'b0;
    #2;
    check("rst_ready",      32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data",  32'(resp_data),  32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_sp",         32'(sp_out),     32'd1023);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // ---------------- vector table ----------------
    vecs.push_back(mk("wr5",        WR,      16'h0005, 16'h1234, 16'h0000, 1'b0, 10'd1023));
    vecs.push_back(mk("rd5",        RD,      16'h0005, 16'h0000, 16'h1234, 1'b0, 10'd1023));
    vecs.push_back(mk("push_a",     PU,      16'h0000, 16'hAAAA, 16'h0000, 1'b0, 10'd1022));
    vecs.push_back(mk("push_b",     PU,      16'h0000, 16'hBBBB, 16'h0000, 1'b0, 10'd1021));
    vecs.push_back(mk("pop_b",      PO,      16'h0000, 16'h0000, 16'hBBBB, 1'b0, 10'd1022));
    vecs.push_back(mk("pop_a",      PO,      16'h0000, 16'h0000, 16'hAAAA, 1'b0, 10'd1023));
    vecs.push_back(mk("pop_empty",  PO,      16'h0000, 16'h0000, 16'h0000, 1'b1, 10'd1023));
    vecs.push_back(mk("wr0",        WR,      16'h0000, 16'h0101, 16'h0000, 1'b0, 10'd1023));
    vecs.push_back(mk("rd_oob",     RD,      16'h0400, 16'h0000, 16'h0000, 1'b1, 10'd1023));
    vecs.push_back(mk("wr_oob",     WR,      16'h0400, 16'h7777, 16'h0000, 1'b1, 10'd1023));
    vecs.push_back(mk("rd0_kept",   RD,      16'h0000, 16'h0000, 16'h0101, 1'b0, 10'd1023));
    vecs.push_back(mk("rdwr_both",  RD | WR, 16'h0005, 16'hFFFF, 16'h0000, 1'b1, 10'd1023));
    vecs.push_back(mk("rd5_kept",   RD,      16'h0005, 16'h0000, 16'h1234, 1'b0, 10'd1023));
    vecs.push_back(mk("no_op",      4'b0000, 16'h0005, 16'h0000, 16'h0000, 1'b1, 10'd1023));
    vecs.push_back(mk("wr_top",     WR,      16'h03FF, 16'hBEEF, 16'h0000, 1'b0, 10'd1023));
    vecs.push_back(mk("rd_top",     RD,      16'h03FF, 16'h0000, 16'hBEEF, 1'b0, 10'd1023));
    vecs.push_back(mk("wr8_a",      WR,      16'h0008, 16'h1111, 16'h0000, 1'b0, 10'd1023));
    vecs.push_back(mk("wr8_b",      WR,      16'h0008, 16'h2222, 16'h0000, 1'b0, 10'd1023));
    vecs.push_back(mk("rd8",        RD,      16'h0008, 16'h0000, 16'h2222, 1'b0, 10'd1023));

    foreach (vecs[i]) begin
      run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rdata, rerr, lat, pulses, low);
      check({vecs[i].name, "_lat"},    32'(lat),    32'd2);
      check({vecs[i].name, "_pulses"}, 32'(pulses), 32'd1);
      check({vecs[i].name, "_low"},    32'(low),    32'd2);
      check({vecs[i].name, "_data"},   32'(rdata),  32'(vecs[i].exp_data));
      check({vecs[i].name, "_err"},    32'(rerr),   32'(vecs[i].exp_err));
      check({vecs[i].name, "_sp"},     32'(sp_out), 32'(vecs[i].exp_sp));
    end

    // ---------------- reset during WAIT aborts the request ----------------
    run_req(WR, 16'h0007, 16'h5555, rdata, rerr, lat, pulses, low);
    check("abort_pre_wr_err", 32'(rerr), 32'd0);
    @(negedge clk);
    {req_read, req_write, req_push, req_pop} = WR;
    req_addr  = 16'h0007;
    req_wdata = 16'h9999;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    {req_read, req_write, req_push, req_pop} = 4'b0000;
    check("abort_in_wait", 32'(req_ready), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("abort_ready_in_rst", 32'(req_ready),  32'd1);
    check("abort_valid_in_rst", 32'(resp_valid), 32'd0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    check("abort_sp",       32'(sp_out), 32'd1023);
    run_req(RD, 16'h0007, 16'h0000, rdata, rerr, lat, pulses, low);
    check("abort_rd7_data", 32'(rdata), 32'h5555);
    check("abort_rd7_err",  32'(rerr),  32'd0);

    // ---------------- fill the stack ----------------
    errs = 0;
    for (int i = 0; i < 1023; i++) begin
      run_req(PU, 16'h0000, 16'(i) ^ 16'hC000, rdata, rerr, lat, pulses, low);
      if (rerr !== 1'b0 || lat != 2 || pulses != 1) errs++;
    end
    check("fill_errs", 32'(errs),   32'd0);
    check("fill_sp",   32'(sp_out), 32'd0);
    run_req(PU, 16'h0000, 16'h5A5A, rdata, rerr, lat, pulses, low);
    check("full_push_err",  32'(rerr),   32'd1);
    check("full_push_data", 32'(rdata),  32'd0);
    check("full_push_sp",   32'(sp_out), 32'd0);
    run_req(PO, 16'h0000, 16'h0000, rdata, rerr, lat, pulses, low);
    check("full_pop_data", 32'(rdata),  32'hC3FE);
    check("full_pop_err",  32'(rerr),   32'd0);
    check("full_pop_sp",   32'(sp_out), 32'd1);

    // ---------------- LATENCY=1 back-to-back ----------------
    @(negedge clk);
    {l1_req_read, l1_req_write, l1_req_push, l1_req_pop} = WR;
    l1_req_addr  = 16'h0003;
    l1_req_wdata = 16'h4242;
    l1_req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("l1_ready_%0d", k), 32'(l1_req_ready),  32'((k % 2) == 0));
      check($sformatf("l1_valid_%0d", k), 32'(l1_resp_valid), 32'((k % 2) == 1));
      if (k == 1) begin
        check("l1_wr_data", 32'(l1_resp_data), 32'd0);
        {l1_req_read, l1_req_write, l1_req_push, l1_req_pop} = RD;
      end
      if (k >= 3 && (k % 2) == 1) begin
        check($sformatf("l1_rd_data_%0d", k), 32'(l1_resp_data), 32'h4242);
        check($sformatf("l1_rd_err_%0d", k),  32'(l1_resp_err),  32'd0);
      end
      @(negedge clk);
    end
    l1_req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
